// File: rtl/counter_74x161_pkg.sv
// Shared constants and helpers for the cascaded 74x161-style synchronous counter.
// Every slice is 4 bits wide. The top level cascades WIDTH/4 slices.
package counter_74x161_pkg;

    localparam int SLICE_W = 4;

    // Only whole numbers of slices, from one to four, are supported.
    function automatic bit legal_width(input int width);
        return (width == 4) || (width == 8) || (width == 12) || (width == 16);
    endfunction

    function automatic bit all_ones(input logic [SLICE_W-1:0] value);
        return &value;
    endfunction

endpackage

// File: rtl/counter_74x161_if.sv
// Bundle of the load/enable/data signals and the count/carry outputs of one counter.
// The controller drives it through the master modport. The counter side uses the slave modport.
interface counter_74x161_if #(
    parameter int WIDTH = 4
);
    logic             load_n;
    logic             enp;
    logic             ent;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    modport master (output load_n, enp, ent, d, input q, rco);
    modport slave  (input load_n, enp, ent, d, output q, rco);
endinterface

// File: rtl/counter_74x161_slice.sv
// One 4-bit slice: clearable register, parallel-load mux, incrementer and slice carry.
// The carry stays combinational so that a chain of slices behaves as one wide counter.
module counter_74x161_slice
    import counter_74x161_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_n,
    input  logic               enp,
    input  logic               ent,
    input  logic [SLICE_W-1:0] d,
    output logic [SLICE_W-1:0] q,
    output logic               rco
);

    // NOTE: state uses non-blocking assignments so that every slice samples the old chain values on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (!load_n) begin
            q <= d;
        end else if (enp && ent) begin
            q <= q + SLICE_W'(1);
        end
    end

    assign rco = ent && all_ones(q);

endmodule

// File: rtl/counter_74x161.sv
// WIDTH-bit synchronous counter built from 4-bit slices.
// Slice k counts only when every lower slice is at all-ones, because its ENT input is the carry of slice k-1.
module counter_74x161
    import counter_74x161_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             LOAD_N,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam int NUM_SLICES = WIDTH / SLICE_W;

    if (!legal_width(WIDTH)) begin : g_bad_width
        $error("counter_74x161: WIDTH=%0d is illegal, use 4, 8, 12 or 16", WIDTH);
    end

    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_slice
        logic ent_in;
        logic rco_out;

        if (k == 0) begin : g_first
            assign ent_in = ENT;
        end else begin : g_chain
            assign ent_in = g_slice[k-1].rco_out;
        end

        counter_74x161_slice u_slice (
            .clk    (CLK),
            .rst_n  (CLR_N),
            .load_n (LOAD_N),
            .enp    (ENP),
            .ent    (ent_in),
            .d      (D[k*SLICE_W +: SLICE_W]),
            .q      (Q[k*SLICE_W +: SLICE_W]),
            .rco    (rco_out)
        );
    end

    assign RCO = g_slice[NUM_SLICES-1].rco_out;

endmodule

// File: tb/tb_counter_74x161.sv
// Bench that runs a 4-bit and an 8-bit counter side by side against an arithmetic model.
// Directed vectors with literal expectations are followed by a randomized phase that only the model checks.
module tb_counter_74x161;

    logic clk   = 1'b0;
    logic clr_n = 1'b1;
    bit   cmp_on = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned m4 = 0;
    int unsigned m8 = 0;

    counter_74x161_if #(.WIDTH(4)) bus4 ();
    counter_74x161_if #(.WIDTH(8)) bus8 ();

    counter_74x161 #(.WIDTH(4)) dut4 (
        .CLK    (clk),
        .CLR_N  (clr_n),
        .LOAD_N (bus4.load_n),
        .ENP    (bus4.enp),
        .ENT    (bus4.ent),
        .D      (bus4.d),
        .Q      (bus4.q),
        .RCO    (bus4.rco)
    );

    counter_74x161 #(.WIDTH(8)) dut8 (
        .CLK    (clk),
        .CLR_N  (clr_n),
        .LOAD_N (bus8.load_n),
        .ENP    (bus8.enp),
        .ENT    (bus8.ent),
        .D      (bus8.d),
        .Q      (bus8.q),
        .RCO    (bus8.rco)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int unsigned next_count(input int unsigned cur, input bit load_n,
                                               input bit enp, input bit ent,
                                               input int unsigned d, input int unsigned modulus);
        if (!load_n)
            return d;
        if (enp && ent)
            return (cur + 1) % modulus;
        return cur;
    endfunction

    // Model: a plain integer count per counter. A low clear forces the count to zero at once.
    always @(posedge clk) begin
        if (!clr_n) begin
            m4 = 0;
            m8 = 0;
        end else begin
            m4 = next_count(m4, bus4.load_n, bus4.enp, bus4.ent, 32'(bus4.d), 16);
            m8 = next_count(m8, bus8.load_n, bus8.enp, bus8.ent, 32'(bus8.d), 256);
        end
    end

    always @(negedge clr_n) begin
        m4 = 0;
        m8 = 0;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            check("model_q4",   32'(bus4.q),   m4);
            check("model_rco4", 32'(bus4.rco), 32'(bus4.ent && (m4 == 15)));
            check("model_q8",   32'(bus8.q),   m8);
            check("model_rco8", 32'(bus8.rco), 32'(bus8.ent && (m8 == 255)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit load_n, input bit enp, input bit ent,
                         input logic [3:0] d4, input logic [7:0] d8);
        bus4.load_n = load_n;
        bus4.enp    = enp;
        bus4.ent    = ent;
        bus4.d      = d4;
        bus8.load_n = load_n;
        bus8.enp    = enp;
        bus8.ent    = ent;
        bus8.d      = d8;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b1, 4'h0, 8'h00);
        #2 clr_n = 1'b0;
        #1;
        check("reset_q4",   32'(bus4.q),   32'h0);
        check("reset_rco4", 32'(bus4.rco), 32'h0);
        check("reset_q8",   32'(bus8.q),   32'h00);
        check("reset_rco8", 32'(bus8.rco), 32'h0);
        cmp_on = 1'b1;

        // A load request and the enables have no effect while clear is held low.
        drive(1'b0, 1'b1, 1'b1, 4'h7, 8'h77);
        tick();
        check("clear_override_q4", 32'(bus4.q), 32'h0);
        clr_n = 1'b1;

        drive(1'b0, 1'b0, 1'b0, 4'h9, 8'h0F);
        tick();
        check("load_q4", 32'(bus4.q), 32'h9);
        check("load_q8", 32'(bus8.q), 32'h0F);

        // Clear between edges must take effect before the next edge arrives.
        drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
        #1 clr_n = 1'b0;
        #1;
        check("midcycle_clear_q4",   32'(bus4.q),   32'h0);
        check("midcycle_clear_rco4", 32'(bus4.rco), 32'h0);
        check("midcycle_clear_q8",   32'(bus8.q),   32'h00);
        #1 clr_n = 1'b1;

        drive(1'b0, 1'b0, 1'b0, 4'hE, 8'h0F);
        tick();
        drive(1'b1, 1'b1, 1'b1, 4'h0, 8'h00);
        tick();
        check("wrap1_q4",   32'(bus4.q),   32'hF);
        check("wrap1_rco4", 32'(bus4.rco), 32'h1);
        check("cascade_q8", 32'(bus8.q),   32'h10);
        check("rco8_low",   32'(bus8.rco), 32'h0);
        tick();
        check("wrap2_q4",   32'(bus4.q),   32'h0);
        check("wrap2_rco4", 32'(bus4.rco), 32'h0);
        check("cascade2_q8", 32'(bus8.q),  32'h11);

        // A load wins over an enabled increment, and D is loaded without being incremented.
        drive(1'b0, 1'b0, 1'b0, 4'h3, 8'hFE);
        tick();
        drive(1'b0, 1'b1, 1'b1, 4'hA, 8'h5A);
        tick();
        check("load_prio_q4", 32'(bus4.q), 32'hA);
        check("load_prio_q8", 32'(bus8.q), 32'h5A);

        drive(1'b0, 1'b0, 1'b0, 4'hF, 8'hFF);
        tick();
        drive(1'b1, 1'b1, 1'b0, 4'h0, 8'h00);
        tick();
        check("ent_low_q4",   32'(bus4.q),   32'hF);
        check("ent_low_rco4", 32'(bus4.rco), 32'h0);
        drive(1'b1, 1'b0, 1'b1, 4'h0, 8'h00);
        tick();
        check("enp_low_q4",   32'(bus4.q),   32'hF);
        check("enp_low_rco4", 32'(bus4.rco), 32'h1);
        check("enp_low_q8",   32'(bus8.q),   32'hFF);
        check("enp_low_rco8", 32'(bus8.rco), 32'h1);
        drive(1'b1, 1'b1, 1'b1, 4'h0, 8'h00);
        tick();
        check("wrap_q8",   32'(bus8.q),   32'h00);
        check("wrap_rco8", 32'(bus8.rco), 32'h0);

        // Randomized phase: input glitches between edges must never reach Q.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 15) != 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 7) != 0), 4'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                bit   save_load_n;
                logic [7:0] save_d8;
                save_load_n = bus8.load_n;
                save_d8     = bus8.d;
                #1;
                bus8.load_n = 1'b0;
                bus8.d      = 8'($urandom);
                #1;
                bus8.load_n = save_load_n;
                bus8.d      = save_d8;
            end
            tick();
        end

        // Clear coincident with a clock edge abandons the pending load.
        drive(1'b0, 1'b1, 1'b1, 4'h5, 8'h5A);
        @(posedge clk);
        clr_n = 1'b0;
        #1;
        check("edge_clear_q8", 32'(bus8.q), 32'h00);
        check("edge_clear_q4", 32'(bus4.q), 32'h0);
        #2 clr_n = 1'b1;
        tick();
        check("post_clear_load_q8", 32'(bus8.q), 32'h5A);
        check("post_clear_load_q4", 32'(bus4.q), 32'h5);

        tick();
        cmp_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
